// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: transmit controller for the UART peripheral.
// Buffers CSR-written bytes in a circular queue and drains them onto the serial
// line as 8N1 frames, CmpVal clock cycles per bit. Raises a one-cycle irq when
// the final queued frame's stop bit completes.
//
// Ports:
//   clk       core clock, rising edge
//   reset_n   asynchronous active-low reset
//   wr_en     FIFO CSR write strobe
//   wr_data   byte to enqueue
//   ovf_clr   clears the sticky overflow flag
//   tx        serial output, idle high, registered
//   level     queued byte count, 0..QueueSize
//   full      level == QueueSize
//   busy      a frame is in progress (FSM not idle)
//   overflow  sticky: a write was dropped
//   irq       one-cycle pulse when the queue has fully drained
module uart_tx_ctrl #(
  parameter int unsigned QueueSize = 32,
  parameter int unsigned PtrSize   = $clog2(QueueSize),
  parameter int unsigned CmpVal    = 173
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             ovf_clr,
  output logic             tx,
  output logic [PtrSize:0] level,
  output logic             full,
  output logic             busy,
  output logic             overflow,
  output logic             irq
);

  localparam int unsigned BaudW = $clog2(CmpVal);
  localparam logic [BaudW-1:0] BaudMax = BaudW'(CmpVal - 1);
  localparam logic [PtrSize:0] PtrOne  = (PtrSize+1)'(1);
  localparam logic [PtrSize:0] QFull   = (PtrSize+1)'(QueueSize);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e             state_q, state_d;
  logic [BaudW-1:0]   baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shreg_q, shreg_d;
  logic               tx_q, tx_d;
  logic               irq_q, irq_d;
  logic               ovf_q, ovf_d;
  logic [PtrSize:0]   wr_ptr_q, rd_ptr_q;
  logic [7:0]         mem [QueueSize];

  logic               pop;
  logic               wr_accept;
  logic               empty;
  logic               baud_end;

  // Extra pointer MSB distinguishes full from empty; subtraction wraps naturally.
  assign level     = wr_ptr_q - rd_ptr_q;
  assign full      = (level == QFull);
  assign empty     = (level == '0);
  assign baud_end  = (baud_q == BaudMax);
  // A pop frees a slot in the same edge, so a write on a full queue still lands.
  assign wr_accept = wr_en && (!full || pop);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_end ? '0 : baud_q + BaudW'(1);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    pop     = 1'b0;
    irq_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shreg_d = mem[rd_ptr_q[PtrSize-1:0]];
          bit_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_end) state_d = StData;
      end
      StData: begin
        if (baud_end) begin
          shreg_d = {1'b0, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (baud_end) begin
          if (!empty) begin
            // Chain straight into the next start bit, no idle gap.
            pop     = 1'b1;
            shreg_d = mem[rd_ptr_q[PtrSize-1:0]];
            bit_d   = '0;
            state_d = StStart;
          end else begin
            state_d = StIdle;
            irq_d   = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // tx is registered from next-state values so it changes on the same edge as the FSM.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // Set wins over clear.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (wr_en && !wr_accept) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
      irq_q    <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      irq_q   <= irq_d;
      ovf_q   <= ovf_d;
      if (wr_accept) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)       rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr_q[PtrSize-1:0]] <= wr_data;
  end

  assign tx       = tx_q;
  assign irq      = irq_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed testbench for uart_tx_ctrl with CmpVal=4 and a 32-byte queue.
module tb_uart_tx_ctrl;

  localparam int CMP = 4;
  localparam int QS  = 32;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       ovf_clr = 1'b0;
  logic       tx;
  logic [5:0] level;
  logic       full, busy, overflow, irq;

  int errors = 0;
  int checks = 0;
  int irq_cnt = 0;
  int irq_snap;
  int waited;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  uart_tx_ctrl #(.QueueSize(QS), .PtrSize(5), .CmpVal(CMP)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data), .ovf_clr(ovf_clr),
    .tx(tx), .level(level), .full(full), .busy(busy), .overflow(overflow), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (irq === 1'b1) irq_cnt <= irq_cnt + 1;

  // Serial decoder: samples each bit on the first falling clock edge inside it.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && tx === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (CMP) @(negedge clk);
          b[i] = tx;
        end
        repeat (CMP) @(negedge clk);
        rx_q.push_back(b);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_byte(input logic [7:0] d);
    wr_data = d;
    wr_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Expected tx for cycle pos (0..39) of a frame carrying byte d.
  function automatic logic exp_bit(input logic [7:0] d, input int pos);
    int idx;
    idx = pos / CMP;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return d[idx-1];
  endfunction

  task automatic wait_drain(input int budget);
    waited = 0;
    while ((busy !== 1'b0 || level !== 6'd0) && waited < budget) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("drain_timeout", (waited < budget) ? 32'd1 : 32'd0, 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic cmp_rx(input string tag);
    chk({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) chk(tag, rx_q[i], exp_q[i]);
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] fb;
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_level", level, 0);
    chk("rst_full", full, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_irq", irq, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single byte 0xA5
    irq_snap = irq_cnt;
    wr_byte(8'hA5);
    chk("single_level_accept", level, 1);
    for (int j = 0; j < 10 * CMP; j++) begin
      @(posedge clk); #1;
      chk("single_tx", tx, exp_bit(8'hA5, j));
      chk("single_busy", busy, 1);
    end
    @(posedge clk); #1;
    chk("single_irq_hi", irq, 1);
    chk("single_busy_lo", busy, 0);
    chk("single_tx_idle", tx, 1);
    @(posedge clk); #1;
    chk("single_irq_lo", irq, 0);
    chk("single_irq_cnt", irq_cnt - irq_snap, 1);
    exp_q.push_back(8'hA5);
    cmp_rx("single_rx");

    // Back-to-back 0x00, 0xFF, 0x55
    repeat (3) @(posedge clk);
    #1;
    irq_snap = irq_cnt;
    wr_byte(8'h00);
    wr_data = 8'hFF;
    wr_en = 1'b1;
    for (int j = 0; j < 30 * CMP; j++) begin
      @(posedge clk); #1;
      if (j == 0) wr_data = 8'h55;
      if (j == 1) wr_en = 1'b0;
      fb = (j < 10 * CMP) ? 8'h00 : (j < 20 * CMP) ? 8'hFF : 8'h55;
      chk("b2b_tx", tx, exp_bit(fb, j % (10 * CMP)));
      chk("b2b_busy", busy, 1);
    end
    @(posedge clk); #1;
    chk("b2b_irq_hi", irq, 1);
    chk("b2b_busy_lo", busy, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("b2b_irq_cnt", irq_cnt - irq_snap, 1);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h55);
    cmp_rx("b2b_rx");

    // Full, overflow and write-on-pop while full
    irq_snap = irq_cnt;
    for (int i = 0; i < 33; i++) begin
      wr_data = 8'h10 + 8'(i);
      wr_en = 1'b1;
      exp_q.push_back(8'h10 + 8'(i));
      @(posedge clk); #1;
    end
    chk("fill_level", level, 32);
    chk("fill_full", full, 1);
    chk("fill_ovf", overflow, 0);
    wr_data = 8'hEE;
    @(posedge clk); #1;
    wr_en = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("ovf_level", level, 32);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    chk("ovf_clr", overflow, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("pre_pop_level", level, 32);
    chk("pre_pop_tx_stop", tx, 1);
    wr_byte(8'h99);
    exp_q.push_back(8'h99);
    chk("popwr_level", level, 32);
    chk("popwr_full", full, 1);
    chk("popwr_ovf", overflow, 0);
    chk("popwr_tx_start", tx, 0);
    wait_drain(2000);
    chk("full_irq_cnt", irq_cnt - irq_snap, 1);
    cmp_rx("full_rx");

    // Pointer wrap: 100 bytes, one write every 30 cycles
    for (int i = 0; i < 100; i++) begin
      wr_byte(8'(i * 37 + 3));
      exp_q.push_back(8'(i * 37 + 3));
      repeat (29) @(posedge clk);
      #1;
    end
    chk("wrap_no_ovf", overflow, 0);
    wait_drain(5000);
    cmp_rx("wrap_rx");

    // Reset during data bit 3
    wr_byte(8'hC3);
    wr_byte(8'h7E);
    repeat (17) @(posedge clk);
    #1;
    chk("mid_tx_bit3", tx, 0);
    chk("mid_level", level, 1);
    chk("mid_busy", busy, 1);
    irq_snap = irq_cnt;
    reset_n = 1'b0;
    #1;
    chk("rstmid_tx", tx, 1);
    chk("rstmid_level", level, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_ovf", overflow, 0);
    chk("rstmid_irq", irq, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    chk("rstmid_no_irq", irq_cnt - irq_snap, 0);
    chk("rstmid_tx_idle", tx, 1);
    rx_q.delete();
    wr_byte(8'h5A);
    exp_q.push_back(8'h5A);
    wait_drain(200);
    chk("post_rst_irq", irq_cnt - irq_snap, 1);
    cmp_rx("post_rst_rx");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
